// File: rtl/bitu_pkg.sv
// Shared types for the GROUP bit-manipulation operand path.
// The operand struct is also consumed by the GROUP stage.
package bitu_pkg;

    localparam int BITU_W = 256;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } entry_state_e;

    typedef struct packed {
        logic [BITU_W-1:0] data;
        logic [BITU_W-1:0] mask;
    } bitu_opnd_t;

endpackage

// File: rtl/bitu_opnd_buf.sv
// One operand-set entry: accumulates beats into {mask, data} and tracks EMPTY/FILLING/FULL.
// Beat k lands at img[k*BEAT_W], so data beats fill the low half and mask beats the high half.
module bitu_opnd_buf
    import bitu_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_beat,
    output bitu_opnd_t        opnd
);

    localparam int NBEATS = BITU_W / BEAT_W;
    localparam int NSLOT  = 2 * NBEATS;

    logic [2*BITU_W-1:0] img;
    entry_state_e        state;
    logic                wr_ok;
    logic                wr_last;

    // A FULL entry is never the write target; the guard keeps a finished pair immutable.
    assign wr_ok   = wr_en && (state != FULL);
    assign wr_last = (wr_idx == IDX_W'(NSLOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (clr) begin
            state <= EMPTY;
        end else if (wr_ok) begin
            state <= wr_last ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img <= '0;
        end else if (clr) begin
            img <= '0;
        end else if (wr_ok) begin
            for (int s = 0; s < NSLOT; s++) begin
                if (wr_idx == IDX_W'(s)) img[s*BEAT_W +: BEAT_W] <= wr_beat;
            end
        end
    end

    assign opnd.data = img[BITU_W-1:0];
    assign opnd.mask = img[2*BITU_W-1:BITU_W];

endmodule

// File: rtl/bitu_operand_loader.sv
// Ping-pong operand loader: assembles {data, mask} from narrow beats and hands
// completed pairs to the GROUP unit over valid/ready.
module bitu_operand_loader
    import bitu_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_beat,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [BITU_W-1:0] op_data,
    output logic [BITU_W-1:0] op_mask,
    output logic              loading
);

    localparam int NBEATS = BITU_W / BEAT_W;
    localparam int IDX_W  = (2 * NBEATS > 1) ? $clog2(2 * NBEATS) : 1;

    logic [IDX_W-1:0] beat_cnt;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             beat_acc;
    logic             last_beat;
    logic             consume;
    bitu_opnd_t       opnd [2];

    assign in_ready  = (cnt < 2'd2);
    assign op_valid  = (cnt != 2'd0);
    assign loading   = (beat_cnt != '0);
    assign beat_acc  = in_valid && in_ready;
    assign last_beat = beat_acc && (beat_cnt == IDX_W'(2 * NBEATS - 1));
    assign consume   = op_valid && op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
        end else if (flush) begin
            beat_cnt <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            if (beat_acc) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (last_beat) wr_ptr <= ~wr_ptr;
            if (consume) rd_ptr <= ~rd_ptr;
            // Simultaneous completion and consume nets out to no change.
            case ({last_beat, consume})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    for (genvar e = 0; e < 2; e++) begin : g_ent
        bitu_opnd_buf #(
            .BEAT_W (BEAT_W),
            .IDX_W  (IDX_W)
        ) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (flush || (consume && (rd_ptr == 1'(e)))),
            .wr_en   (beat_acc && (wr_ptr == 1'(e))),
            .wr_idx  (beat_cnt),
            .wr_beat (in_beat),
            .opnd    (opnd[e])
        );
    end

    assign op_data = opnd[rd_ptr].data;
    assign op_mask = opnd[rd_ptr].mask;

endmodule

// File: tb/tb_bitu_operand_loader.sv
// Directed bench for bitu_operand_loader with BEAT_W=64 (8 beats per operation).
module tb_bitu_operand_loader;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_beat;
    logic         op_valid;
    logic         op_ready;
    logic [255:0] op_data;
    logic [255:0] op_mask;
    logic         loading;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] t_d, t_m, a_d, a_m, b_d, b_m, c_d, c_m;

    bitu_operand_loader #(.BEAT_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_beat  (in_beat),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_data  (op_data),
        .op_mask  (op_mask),
        .loading  (loading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives beats [first, last) of operation {m, d}, one per cycle.
    task automatic send_beats(input logic [255:0] d, input logic [255:0] m,
                              input int first, input int last);
        for (int k = first; k < last; k++) begin
            in_beat  = (k < 4) ? d[k*64 +: 64] : m[(k-4)*64 +: 64];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_beat = '0; op_ready = 1'b0;
        t_d = {64'h3, 64'h2, 64'h1, 64'h0};
        t_m = '1;
        a_d = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        a_m = {64'h00F0_00F0_00F0_00F3, 64'h00F0_00F0_00F0_00F2, 64'h00F0_00F0_00F0_00F1, 64'h00F0_00F0_00F0_00F0};
        b_d = {64'hB3B3_B3B3_1111_2222, 64'hB2B2_B2B2_3333_4444, 64'hB1B1_B1B1_5555_6666, 64'hB0B0_B0B0_7777_8888};
        b_m = {64'h8000_0000_0000_0003, 64'h4000_0000_0000_0002, 64'h2000_0000_0000_0001, 64'h1000_0000_0000_0000};
        c_d = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
        c_m = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};

        // Reset values
        #12;
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        chk("rst_op_valid", 256'(op_valid), 256'd0);
        chk("rst_op_data", op_data, 256'd0);
        chk("rst_op_mask", op_mask, 256'd0);
        chk("rst_loading", 256'(loading), 256'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single operation, op_ready high: valid one cycle after beat 7
        op_ready = 1'b1;
        send_beats(t_d, t_m, 0, 7);
        chk("t1_valid_before_last", 256'(op_valid), 256'd0);
        chk("t1_loading_mid", 256'(loading), 256'd1);
        send_beats(t_d, t_m, 7, 8);
        chk("t1_valid", 256'(op_valid), 256'd1);
        chk("t1_data", op_data, {64'h3, 64'h2, 64'h1, 64'h0});
        chk("t1_mask", op_mask, {256{1'b1}});
        chk("t1_loading_done", 256'(loading), 256'd0);
        step();
        chk("t1_consumed", 256'(op_valid), 256'd0);
        chk("t1_data_cleared", op_data, 256'd0);

        // Two operations buffered with op_ready low, then drained in order
        op_ready = 1'b0;
        send_beats(a_d, a_m, 0, 8);
        chk("t2_ready_one_full", 256'(in_ready), 256'd1);
        send_beats(b_d, b_m, 0, 8);
        chk("t2_ready_both_full", 256'(in_ready), 256'd0);
        in_valid = 1'b1; in_beat = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        step();
        chk("t2_17th_ready", 256'(in_ready), 256'd0);
        chk("t2_17th_loading", 256'(loading), 256'd0);
        chk("t2_hold_a_data", op_data, a_d);
        chk("t2_hold_a_mask", op_mask, a_m);
        in_valid = 1'b0;
        op_ready = 1'b1;
        step();
        chk("t2_b_valid", 256'(op_valid), 256'd1);
        chk("t2_b_data", op_data, b_d);
        chk("t2_b_mask", op_mask, b_m);
        step();
        chk("t2_drained", 256'(op_valid), 256'd0);
        chk("t2_no_stray_beat", 256'(loading), 256'd0);

        // Final beat of B coincides with consume of A
        op_ready = 1'b0;
        send_beats(a_d, a_m, 0, 8);
        send_beats(b_d, b_m, 0, 7);
        chk("t3_ready_partial", 256'(in_ready), 256'd1);
        chk("t3_loading_partial", 256'(loading), 256'd1);
        chk("t3_a_data", op_data, a_d);
        op_ready = 1'b1;
        send_beats(b_d, b_m, 7, 8);
        chk("t3_b_valid", 256'(op_valid), 256'd1);
        chk("t3_b_data", op_data, b_d);
        chk("t3_b_mask", op_mask, b_m);
        step();
        chk("t3_drained", 256'(op_valid), 256'd0);

        // Flush with a full entry and a partial load, beat offered in flush cycle
        op_ready = 1'b0;
        send_beats(a_d, a_m, 0, 8);
        send_beats(b_d, b_m, 0, 3);
        chk("t4_loading_pre", 256'(loading), 256'd1);
        in_valid = 1'b1; in_beat = b_d[3*64 +: 64]; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t4_loading", 256'(loading), 256'd0);
        chk("t4_valid", 256'(op_valid), 256'd0);
        chk("t4_data_zero", op_data, 256'd0);
        chk("t4_mask_zero", op_mask, 256'd0);
        send_beats(c_d, c_m, 0, 8);
        chk("t4_c_valid", 256'(op_valid), 256'd1);
        chk("t4_c_data", op_data, c_d);
        chk("t4_c_mask", op_mask, c_m);
        op_ready = 1'b1;
        step();
        chk("t4_drained", 256'(op_valid), 256'd0);

        // Asynchronous reset mid-load with one entry full
        op_ready = 1'b0;
        send_beats(a_d, a_m, 0, 8);
        send_beats(b_d, b_m, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", 256'(op_valid), 256'd0);
        chk("t5_in_ready", 256'(in_ready), 256'd1);
        chk("t5_loading", 256'(loading), 256'd0);
        chk("t5_data", op_data, 256'd0);
        chk("t5_mask", op_mask, 256'd0);
        step();
        rst_n = 1'b1;
        send_beats(c_d, c_m, 0, 8);
        chk("t5_c_valid", 256'(op_valid), 256'd1);
        chk("t5_c_data", op_data, c_d);
        chk("t5_c_mask", op_mask, c_m);
        op_ready = 1'b1;
        step();
        chk("t5_drained", 256'(op_valid), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitu_operand_loader.md
# bitu_operand_loader

Upstream feeder for the 256-bit GROUP bit-manipulation unit. It assembles a 256-bit data operand and a 256-bit bitmask operand from narrow beats delivered by the core's operand bus, then presents the completed pair to the GROUP unit through a valid/ready handshake. It holds two operand sets in a ping-pong buffer, so the next operation loads while the current one waits to be consumed.

## Interface
- BEAT_W, 64, input beat width in bits; legal values 32, 64, 128, 256.
- NBEATS, 256/BEAT_W, derived (localparam); beats per operand.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous discard of all partial and buffered operands.
- in_valid  input  1  beat valid.
- in_ready  output  1  loader can accept a beat.
- in_beat  input  BEAT_W  beat payload.
- op_valid  output  1  a complete {data, mask} pair is presented.
- op_ready  input  1  GROUP stage consumes the pair.
- op_data  output  256  data operand (data_in of the GROUP unit).
- op_mask  output  256  bitmask operand (bitmask of the GROUP unit).
- loading  output  1  a partially loaded operand set exists.

## Operation
- Beat order per operation is fixed: beats 0..NBEATS-1 fill data, least-significant slice first. Beats NBEATS..2*NBEATS-1 fill mask, least-significant slice first.
- Beat k < NBEATS is written to data[k*BEAT_W +: BEAT_W]. Beat k ≥ NBEATS is written to mask[(k-NBEATS)*BEAT_W +: BEAT_W].
- Beat counter: width $clog2(2*NBEATS), minimum 1 bit. It increments on each accepted beat. After the final beat (2*NBEATS-1) it wraps to 0.
- Two entries (0, 1). Each entry is EMPTY, FILLING or FULL.
- wr_ptr selects the entry being filled. rd_ptr selects the entry presented on op_*. cnt (0..2) holds the number of FULL entries.
- Beat accepted: in_valid & in_ready.
  - The target entry becomes FILLING on its first beat.
  - On its final beat it becomes FULL, cnt increments, wr_ptr toggles and the beat counter resets to 0.
- Pair consumed: op_valid & op_ready. The rd_ptr entry becomes EMPTY, cnt decrements and rd_ptr toggles.
- A final beat and a consume in the same cycle leave cnt unchanged; both pointers toggle.
- in_ready = (cnt < 2). A partial load therefore continues while one entry is FULL.
- op_valid = (cnt > 0).
- op_data and op_mask come from the rd_ptr entry registers; they are X-free and all-zero when empty.
- loading = (beat counter ≠ 0).
- flush has priority over both handshakes in the same cycle. It forces cnt=0, wr_ptr=rd_ptr=0, beat counter=0 and both entries to EMPTY. Entry contents are zeroed. Beats and consumes in the flush cycle are dropped.
- in_valid with in_ready low is ignored. The source holds in_beat until accepted.

## Timing
- Reset (rst_n low, asynchronous):
  - cnt=0, pointers=0, beat counter=0, entries zeroed.
  - op_valid=0, op_data=0, op_mask=0, loading=0, in_ready=1.
- Latency: op_valid rises the cycle after the final beat is accepted.
- Throughput: one operation per 2*NBEATS cycles with continuous in_valid and op_ready. With BEAT_W=64 that is 8 cycles per operation, with no bubbles.
- With op_ready held low, the loader accepts up to 2 complete operations (4*NBEATS beats), then in_ready=0 until a consume.
- op_* are stable while op_valid=1 and op_ready=0.
- Reset deasserted mid-operation: everything restarts at beat 0. No partial state survives.

## Structure
- Package bitu_pkg holds:
  - localparam BITU_W=256.
  - Typedef entry_state_e {EMPTY, FILLING, FULL}.
  - Typedef bitu_opnd_t (struct of 256-bit data and 256-bit mask), shared with the GROUP stage.
- Sub-module bitu_opnd_buf: one entry. It takes a beat write port (index, payload, write enable), a clear, and outputs bitu_opnd_t. It is instantiated twice.
- Top-level logic holds the beat counter, the pointers, cnt and the handshakes.

## Test plan
- BEAT_W=64, reset → in_ready=1, op_valid=0, op_data=op_mask=0, loading=0.
- 8 beats: data 64'h0..3 then mask 64'hFFFF_FFFF_FFFF_FFFF ×4, op_ready=1 → op_valid one cycle after beat 7, op_data={64'h3,64'h2,64'h1,64'h0}, op_mask=all ones, consumed in 1 cycle.
- op_ready=0, 16 beats of two distinct operations → in_ready drops after beat 15. A 17th beat is not accepted. Raising op_ready presents operation A, then operation B, in order.
- Final beat of operation B coincides with consume of operation A → cnt stays 1, op_* switch to B next cycle, no lost beats.
- flush asserted after 3 beats, with in_valid high in the same cycle → loading=0, op_valid=0. The next 8 beats form a clean operation starting at beat 0.
- rst_n pulled low asynchronously mid-load with one entry FULL → outputs return to reset values immediately, and the next load completes correctly.
